// File: rtl/reqack_pkg.sv
// Shared types, defaults and helpers for the req/ack responder and its checker.
package reqack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ACK   = 3'd2,
        ST_WORK  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ABORT = 3'd5
    } reqack_state_t;

    // Latency bound shared with the req/ack equivalence checker's max.
    localparam int REQACK_MAX_LAT = 5;
    localparam int REQACK_CNT_W   = 4;

    // Map the requested delay into 1..max_lat (0 becomes 1).
    function automatic logic [REQACK_CNT_W-1:0] clamp_delay(
        input logic [2:0]              raw,
        input logic [REQACK_CNT_W-1:0] max_lat
    );
        logic [REQACK_CNT_W-1:0] wide;
        wide = REQACK_CNT_W'(raw);
        if (wide == {REQACK_CNT_W{1'b0}}) begin
            return REQACK_CNT_W'(1);
        end else if (wide > max_lat) begin
            return max_lat;
        end else begin
            return wide;
        end
    endfunction

endpackage

// File: rtl/reqack_down_cnt.sv
// Loadable down-counter used for both the req-to-ack wait and the work phase.
module reqack_down_cnt
    import reqack_pkg::*;
#(
    parameter int CNT_W = REQACK_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;

    // Load has priority over decrement; the count parks at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= val;
        end else if (en && !zero) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/reqack_responder.sv
// Responder side of the four-phase req/ack/done handshake with interrupt abort.
module reqack_responder
    import reqack_pkg::*;
#(
    parameter int MAX_LAT  = REQACK_MAX_LAT,
    parameter int XFER_CYC = 3,
    parameter int CNT_W    = REQACK_CNT_W
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req,
    input  logic       intrpt,
    input  logic [2:0] cfg_delay,
    output logic       ack,
    output logic       done,
    output logic       busy,
    output logic       err,
    output logic [7:0] abort_cnt
);

    reqack_state_t state_r;
    reqack_state_t state_s;

    logic             ack_r, ack_s;
    logic             done_r, done_s;
    logic             busy_r;
    logic             err_r, err_s;
    logic [7:0]       abort_cnt_r;
    logic             abort_inc_s;

    logic             cnt_load_s;
    logic             cnt_en_s;
    logic [CNT_W-1:0] cnt_val_s;
    logic             cnt_zero_s;
    logic [CNT_W-1:0] wait_val_s;
    logic [CNT_W-1:0] work_val_s;

    // The counter holds "cycles remaining minus one", so a phase ends on the
    // edge that finds it already at zero: load d-1 to see ack after edge k+d.
    assign wait_val_s = CNT_W'(clamp_delay(cfg_delay, REQACK_CNT_W'(MAX_LAT))) - CNT_W'(1);
    assign work_val_s = CNT_W'(XFER_CYC - 1);

    reqack_down_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (cnt_load_s),
        .val     (cnt_val_s),
        .en      (cnt_en_s),
        .zero    (cnt_zero_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-output decode; intrpt outranks err and normal moves.
    always_comb begin
        state_s     = state_r;
        ack_s       = 1'b0;
        done_s      = 1'b0;
        err_s       = 1'b0;
        abort_inc_s = 1'b0;
        cnt_load_s  = 1'b0;
        cnt_en_s    = 1'b0;
        cnt_val_s   = wait_val_s;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    state_s    = ST_WAIT;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = wait_val_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (intrpt) begin
                    state_s     = ST_ABORT;
                    abort_inc_s = 1'b1;
                end else if (!req) begin
                    state_s = ST_IDLE;
                    err_s   = 1'b1;
                end else if (cnt_zero_s) begin
                    state_s = ST_ACK;
                    ack_s   = 1'b1;
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            ST_ACK: begin
                if (intrpt) begin
                    state_s     = ST_ABORT;
                    abort_inc_s = 1'b1;
                end else if (!req) begin
                    state_s    = ST_WORK;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = work_val_s;
                end else begin
                    ack_s = 1'b1;
                end
            end
            ST_WORK: begin
                if (intrpt) begin
                    state_s     = ST_ABORT;
                    abort_inc_s = 1'b1;
                end else if (cnt_zero_s) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            ST_ABORT: begin
                if (!req) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ABORT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_r  <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            ack_r  <= ack_s;
            done_r <= done_s;
            err_r  <= err_s;
            busy_r <= (state_s != ST_IDLE);
        end
    end

    // Saturating abort counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            abort_cnt_r <= 8'd0;
        end else if (abort_inc_s && (abort_cnt_r != 8'hFF)) begin
            abort_cnt_r <= abort_cnt_r + 8'd1;
        end else begin
            abort_cnt_r <= abort_cnt_r;
        end
    end

    assign ack       = ack_r;
    assign done      = done_r;
    assign busy      = busy_r;
    assign err       = err_r;
    assign abort_cnt = abort_cnt_r;

endmodule

// File: tb/tb_reqack_responder.sv
// Self-checking bench: directed vector table, saturation/reset sequences, random run vs model.
module tb_reqack_responder;

    localparam int MAX_LAT  = 5;
    localparam int XFER_CYC = 3;

    logic       clk;
    logic       reset_n;
    logic       req;
    logic       intrpt;
    logic [2:0] cfg_delay;
    logic       ack;
    logic       done;
    logic       busy;
    logic       err;
    logic [7:0] abort_cnt;

    int checks;
    int failures;

    reqack_responder #(
        .MAX_LAT  (MAX_LAT),
        .XFER_CYC (XFER_CYC),
        .CNT_W    (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .intrpt    (intrpt),
        .cfg_delay (cfg_delay),
        .ack       (ack),
        .done      (done),
        .busy      (busy),
        .err       (err),
        .abort_cnt (abort_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       req;
        logic       intrpt;
        logic [2:0] cfg;
        logic       ack;
        logic       done;
        logic       busy;
        logic       err;
        logic [7:0] abort;
    } vec_t;

    vec_t vecs[$];

    // Transaction-level reference: phases with absolute deadline edges.
    localparam int P_IDLE  = 0;
    localparam int P_PEND  = 1;
    localparam int P_ACKED = 2;
    localparam int P_WORK  = 3;
    localparam int P_DONE  = 4;
    localparam int P_ABORT = 5;

    int m_phase;
    int m_deadline;
    int m_abort;
    int edge_no;
    bit m_err;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int clampd(input logic [2:0] c);
        if (c == 3'd0) return 1;
        if (int'(c) > MAX_LAT) return MAX_LAT;
        return int'(c);
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_abort = 0;
        m_err   = 1'b0;
    endtask

    task automatic model_abort();
        m_phase = P_ABORT;
        if (m_abort < 255) m_abort++;
    endtask

    task automatic model_edge(input logic r, input logic i, input logic [2:0] c);
        edge_no++;
        m_err = 1'b0;
        case (m_phase)
            P_IDLE:  if (r) begin m_phase = P_PEND; m_deadline = edge_no + clampd(c); end
            P_PEND:  if (i) model_abort();
                     else if (!r) begin m_err = 1'b1; m_phase = P_IDLE; end
                     else if (edge_no == m_deadline) m_phase = P_ACKED;
            P_ACKED: if (i) model_abort();
                     else if (!r) begin m_phase = P_WORK; m_deadline = edge_no + XFER_CYC; end
            P_WORK:  if (i) model_abort();
                     else if (edge_no == m_deadline) m_phase = P_DONE;
            P_DONE:  m_phase = P_IDLE;
            P_ABORT: if (!r) m_phase = P_IDLE;
            default: m_phase = P_IDLE;
        endcase
    endtask

    // Apply inputs at the falling edge, let one rising edge pass, return at the next falling edge.
    task automatic step(input logic r, input logic i, input logic [2:0] c);
        req       = r;
        intrpt    = i;
        cfg_delay = c;
        @(posedge clk);
        model_edge(r, i, c);
        @(negedge clk);
    endtask

    task automatic v(input logic r, input logic i, input logic [2:0] c, input logic a,
                     input logic d, input logic b, input logic e, input logic [7:0] ab);
        vec_t t;
        t.req = r; t.intrpt = i; t.cfg = c; t.ack = a; t.done = d; t.busy = b; t.err = e; t.abort = ab;
        vecs.push_back(t);
    endtask

    initial begin
        checks = 0; failures = 0; edge_no = 0;
        model_reset();
        reset_n = 1'b0; req = 1'b0; intrpt = 1'b0; cfg_delay = 3'd0;

        // req / intrpt / cfg -> ack done busy err abort_cnt (after the edge)
        // Nominal, cfg_delay=2: ack after 2 edges, done 3 edges after req drop.
        v(1,0,2, 0,0,1,0, 0); v(1,0,2, 0,0,1,0, 0); v(1,0,2, 1,0,1,0, 0);
        v(0,0,2, 0,0,1,0, 0); v(0,0,2, 0,0,1,0, 0); v(0,0,2, 0,0,1,0, 0);
        v(0,0,2, 0,1,1,0, 0); v(0,0,2, 0,0,0,0, 0);
        // Early withdrawal, cfg_delay=4.
        v(1,0,4, 0,0,1,0, 0); v(0,0,4, 0,0,0,1, 0); v(0,0,4, 0,0,0,0, 0);
        // cfg_delay=0 clamps to 1.
        v(1,0,0, 0,0,1,0, 0); v(1,0,0, 1,0,1,0, 0); v(0,0,0, 0,0,1,0, 0);
        v(0,0,0, 0,0,1,0, 0); v(0,0,0, 0,0,1,0, 0); v(0,0,0, 0,1,1,0, 0);
        v(0,0,0, 0,0,0,0, 0);
        // cfg_delay=7 clamps to 5; req re-asserted during DONE is taken one edge later.
        v(1,0,7, 0,0,1,0, 0); v(1,0,7, 0,0,1,0, 0); v(1,0,7, 0,0,1,0, 0);
        v(1,0,7, 0,0,1,0, 0); v(1,0,7, 0,0,1,0, 0); v(1,0,7, 1,0,1,0, 0);
        v(1,0,7, 1,0,1,0, 0); v(0,0,7, 0,0,1,0, 0); v(0,0,7, 0,0,1,0, 0);
        v(0,0,7, 0,0,1,0, 0); v(1,0,0, 0,1,1,0, 0); v(1,0,0, 0,0,0,0, 0);
        v(1,0,0, 0,0,1,0, 0); v(1,0,0, 1,0,1,0, 0); v(0,0,0, 0,0,1,0, 0);
        v(0,0,0, 0,0,1,0, 0); v(0,0,0, 0,0,1,0, 0); v(0,0,0, 0,1,1,0, 0);
        v(0,0,0, 0,0,0,0, 0);
        // intrpt with req withdrawal in WAIT: abort, no err.
        v(1,0,3, 0,0,1,0, 0); v(0,1,3, 0,0,1,0, 1); v(0,0,3, 0,0,0,0, 1);
        // intrpt on the 2nd WORK cycle: no done, ABORT holds while req high.
        v(1,0,0, 0,0,1,0, 1); v(1,0,0, 1,0,1,0, 1); v(0,0,0, 0,0,1,0, 1);
        v(0,0,0, 0,0,1,0, 1); v(1,1,0, 0,0,1,0, 2); v(1,0,0, 0,0,1,0, 2);
        v(1,1,0, 0,0,1,0, 2); v(0,0,0, 0,0,0,0, 2); v(0,0,0, 0,0,0,0, 2);
        // intrpt ignored in IDLE; intrpt in ACK drops ack, stale req not re-acked.
        v(0,1,0, 0,0,0,0, 2); v(1,0,0, 0,0,1,0, 2); v(1,0,0, 1,0,1,0, 2);
        v(1,1,0, 0,0,1,0, 3); v(1,0,0, 0,0,1,0, 3); v(1,0,0, 0,0,1,0, 3);
        v(0,0,0, 0,0,0,0, 3);

        @(negedge clk); @(negedge clk);
        chk("reset ack", ack, 0);   chk("reset done", done, 0);
        chk("reset busy", busy, 0); chk("reset err", err, 0);
        chk("reset abort_cnt", abort_cnt, 0);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (vecs[n]) begin
            step(vecs[n].req, vecs[n].intrpt, vecs[n].cfg);
            chk($sformatf("vec%0d ack", n), ack, vecs[n].ack);
            chk($sformatf("vec%0d done", n), done, vecs[n].done);
            chk($sformatf("vec%0d busy", n), busy, vecs[n].busy);
            chk($sformatf("vec%0d err", n), err, vecs[n].err);
            chk($sformatf("vec%0d abort_cnt", n), abort_cnt, vecs[n].abort);
        end

        // 260 further aborts saturate the counter.
        for (int a = 0; a < 260; a++) begin
            step(1'b1, 1'b0, 3'd2);
            step(1'b1, 1'b1, 3'd2);
            step(1'b0, 1'b0, 3'd2);
            if (a == 9) chk("abort_cnt after 13", abort_cnt, 13);
        end
        chk("abort_cnt saturated", abort_cnt, 255);

        // Asynchronous reset in the middle of ACK.
        step(1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b0, 3'd0);
        chk("pre-reset ack", ack, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset ack", ack, 0);
        chk("async reset busy", busy, 0);
        chk("async reset abort_cnt", abort_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 3'd0);
        chk("post-reset ack", ack, 0);
        chk("post-reset busy", busy, 1);
        step(1'b1, 1'b0, 3'd0);
        chk("post-reset ack rise", ack, 1);

        // Random traffic against the reference model.
        begin
            logic r;
            r = 1'b1;
            for (int c = 0; c < 1500; c++) begin
                if ($urandom_range(0, 5) == 0) r = ~r;
                step(r, ($urandom_range(0, 19) == 0), 3'($urandom_range(0, 7)));
                chk($sformatf("rnd%0d ack", c), ack, (m_phase == P_ACKED) ? 1 : 0);
                chk($sformatf("rnd%0d done", c), done, (m_phase == P_DONE) ? 1 : 0);
                chk($sformatf("rnd%0d busy", c), busy, (m_phase != P_IDLE) ? 1 : 0);
                chk($sformatf("rnd%0d err", c), err, m_err ? 1 : 0);
                chk($sformatf("rnd%0d abort_cnt", c), abort_cnt, m_abort);
                chk($sformatf("rnd%0d ack&done", c), (ack & done), 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reqack_responder.md
# reqack_responder

Responder side of the four-phase req/ack/done handshake, with interrupt abort. Synthesizable. It samples `req` from an initiator and raises `ack` after a programmable bounded latency. It holds `ack` until `req` falls, runs a fixed work phase, then pulses `done`. It is the design-under-test counterpart that the req/ack equivalence assertions are bound against, so its latency bound matches the checker's `max` (5).

## Interface
- `MAX_LAT`, 5: upper bound in cycles from `req` sampled high to `ack` high.
- `XFER_CYC`, 3: work-phase length in cycles from `ack` falling to `done` pulse; legal range 1..15.
- `CNT_W`, 4: width of the internal latency/work down-counter; must hold max(`MAX_LAT`, `XFER_CYC`).
- `clk`  in  1  single clock, all state updates on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  request from initiator, level.
- `intrpt`  in  1  abort request, level, sampled on posedge.
- `cfg_delay`  in  3  requested req-to-ack latency, sampled on IDLE→WAIT.
- `ack`  out  1  acknowledge, registered.
- `done`  out  1  one-cycle completion pulse, registered.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  one-cycle pulse: `req` withdrawn before `ack`.
- `abort_cnt`  out  8  saturating count of interrupt aborts.

## Operation
- FSM states are IDLE, WAIT, ACK, WORK, DONE and ABORT.
- **IDLE**
  - `req`=1 → WAIT.
  - The counter loads d = clamp(`cfg_delay`, 1, `MAX_LAT`): 0 maps to 1, values above `MAX_LAT` map to `MAX_LAT`.
- **WAIT**
  - Counter decrements each cycle.
  - On reaching the final count → ACK, with `ack` set.
  - `req`=0 before that → `err` pulse, back to IDLE.
- **ACK**
  - `ack` held high while `req`=1.
  - `req` sampled 0 → WORK: `ack` cleared, counter loads `XFER_CYC`.
- **WORK**
  - Counter decrements.
  - On expiry → DONE: `done`=1 for exactly one cycle.
- **DONE** → IDLE unconditionally. A `req` already high is taken on the following edge; no same-cycle re-entry.
- **Interrupt**
  - `intrpt`=1 sampled in WAIT, ACK or WORK → ABORT.
  - Effects on the same edge: `ack`←0, no `done`, `abort_cnt` +1 (saturates at 255).
  - `intrpt` has priority over `err` and over normal transitions on the same edge.
  - `intrpt` is ignored in IDLE, DONE and ABORT.
- **ABORT** waits for `req`=0, then → IDLE. This prevents a stale request from being re-acknowledged.
- `ack` and `done` are never high simultaneously. `ack` never rises while `req`=0.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0, `abort_cnt` 0. Applied asynchronously on `reset_n` fall.
- Reset mid-transfer drops `ack`/`done` immediately; no completion is reported.
- Release is synchronous to the next posedge.
- Latency, with `req` first sampled high at edge k:
  - `ack` is high after edge k+d, 1 ≤ d ≤ `MAX_LAT`.
  - `req` sampled low at edge m → `ack` low after edge m.
  - `done` is high for the single cycle after edge m+`XFER_CYC`.
- Minimum full transaction, IDLE to IDLE: d + `XFER_CYC` + 3 cycles, including the minimum 1-cycle req-high hold after `ack`.
- `busy` rises after edge k and falls after the DONE→IDLE or ABORT→IDLE edge.

## Structure
- Package `reqack_pkg` holds:
  - the state enum `reqack_state_t`;
  - the localparam default `REQACK_MAX_LAT` = 5, shared with the assertion checker's `max`;
  - the `clamp_delay` function.
- Sub-module `reqack_down_cnt` is a loadable down-counter with `load`, `val`, `en` and `zero` ports, reused for both the WAIT and WORK phases.
- The top level contains the FSM, output registers and the saturating `abort_cnt`.

## Test plan
- Nominal transfer, `cfg_delay`=2, `req` at edge 10, dropped one cycle after `ack`:
  - `ack` high after edges 12..13.
  - `done` pulse after edge 16 (`XFER_CYC`=3).
  - `busy` 0 after edge 17.
- Latency clamping: `cfg_delay`=0 → `ack` 1 cycle after `req`; `cfg_delay`=7 → `ack` 5 cycles after `req`. The equivalence checker passes in both cases.
- Early withdrawal: `req` high 1 cycle with `cfg_delay`=4 → `err` pulse once, `ack` never rises, return to IDLE.
- Interrupt during WORK: `intrpt` on the 2nd WORK cycle → no `done`, `abort_cnt`=1, ABORT until `req`=0. `intrpt` coinciding with `req` withdrawal in WAIT yields ABORT, not `err`.
- Saturation and reset: 260 aborts → `abort_cnt`=255. `reset_n` low mid-ACK → `ack`=0 immediately, `abort_cnt`=0, IDLE after release.
- Back-to-back: `req` re-asserted during the DONE cycle → second `ack` d cycles after the edge following DONE. No overlap of `ack` and `done`.
